// File: rtl/arith_subi_rr_arbiter.sv
// ============================================================================
// Module   : arith_subi_rr_arbiter (with arith_subi datapath)
// Brief    : Round-robin sharing of one integer subtractor among NUM_REQ
//            valid/ready requesters, with a 1-entry result buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arith_subi #(
    parameter int WIDTH = 32
) (
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result_data
);
    // Unbuffered: operands pass straight through, wrapping modulo 2^WIDTH.
    assign result_data  = a_data - b_data;
    assign result_valid = a_valid & b_valid;
    assign a_ready      = result_ready;
    assign b_ready      = result_ready;
endmodule

module arith_subi_rr_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_data,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_data,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]         resp_data,
    output logic                     busy
);
    localparam int                   c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_idx_w:0]     c_num   = (c_idx_w+1)'(NUM_REQ);
    localparam logic [c_idx_w-1:0]   c_last  = c_idx_w'(NUM_REQ - 1);

    logic [c_idx_w-1:0] w_rr_ptr;
    logic [c_idx_w-1:0] w_grant;
    logic               w_found;
    logic [c_idx_w:0]   w_scan;
    logic [WIDTH-1:0]   w_a_sel;
    logic [WIDTH-1:0]   w_b_sel;
    logic               w_owner_ready;
    logic               w_slot_free;
    logic               w_any_valid;
    logic               w_sub_a_ready;
    logic               w_sub_b_ready;
    logic               w_sub_valid;
    logic [WIDTH-1:0]   w_sub_data;
    logic               w_accept;
    logic               w_drain;

    logic               r_buf_valid;
    logic [c_idx_w-1:0] r_buf_owner;
    logic [WIDTH-1:0]   r_buf_data;

    // Scan from the farthest offset down so the nearest valid requester wins.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_scan  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_scan = {1'b0, w_rr_ptr} + (c_idx_w+1)'(k);
            if (w_scan >= c_num) begin
                w_scan = w_scan - c_num;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_scan == (c_idx_w+1)'(i) && req_valid[i]) begin
                    w_found = 1'b1;
                    w_grant = c_idx_w'(i);
                end
            end
        end
    end

    always_comb begin
        w_a_sel       = '0;
        w_b_sel       = '0;
        w_owner_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == c_idx_w'(i)) begin
                w_a_sel = req_a_data[i*WIDTH +: WIDTH];
                w_b_sel = req_b_data[i*WIDTH +: WIDTH];
            end
            if (r_buf_owner == c_idx_w'(i)) begin
                w_owner_ready = resp_ready[i];
            end
        end
    end

    assign w_slot_free = ~r_buf_valid | w_owner_ready;
    assign w_any_valid = |req_valid;

    arith_subi #(
        .WIDTH (WIDTH)
    ) u_subi (
        .a_valid      (w_any_valid),
        .a_data       (w_a_sel),
        .a_ready      (w_sub_a_ready),
        .b_valid      (w_any_valid),
        .b_data       (w_b_sel),
        .b_ready      (w_sub_b_ready),
        .result_valid (w_sub_valid),
        .result_ready (w_slot_free),
        .result_data  (w_sub_data)
    );

    assign w_accept = w_sub_valid & w_sub_a_ready & w_sub_b_ready;
    assign w_drain  = r_buf_valid & w_owner_ready;

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i]  = w_found & (w_grant == c_idx_w'(i)) & w_sub_a_ready & w_sub_b_ready;
            resp_valid[i] = r_buf_valid & (r_buf_owner == c_idx_w'(i));
        end
    end

    assign resp_data = r_buf_data;
    assign busy      = r_buf_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf_owner <= '0;
            r_buf_data  <= '0;
        end else if (w_accept) begin
            r_buf_valid <= 1'b1;
            r_buf_owner <= w_grant;
            r_buf_data  <= w_sub_data;
        end else if (w_drain) begin
            r_buf_valid <= 1'b0;
        end
    end

    generate
        if (NUM_REQ > 1) begin : g_multi_ptr
            logic [c_idx_w-1:0] r_rr_ptr;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rr_ptr <= '0;
                end else if (w_accept) begin
                    r_rr_ptr <= (w_grant == c_last) ? '0 : w_grant + c_idx_w'(1);
                end
            end
            assign w_rr_ptr = r_rr_ptr;
        end else begin : g_single_ptr
            assign w_rr_ptr = '0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_arith_subi_rr_arbiter.sv
// ============================================================================
// Module   : tb_arith_subi_rr_arbiter
// Brief    : Directed and randomized checks of arith_subi_rr_arbiter against
//            a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arith_subi_rr_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a_data;
    logic [N*W-1:0] req_b_data;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_ready;
    logic [W-1:0]   resp_data;
    logic           busy;

    always #5 clk = ~clk;

    arith_subi_rr_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a_data (req_a_data),
        .req_b_data (req_b_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    int           total = 0;
    int           bad   = 0;
    int           m_ptr;
    bit           m_full;
    int           m_owner;
    logic [W-1:0] sb[N][$];
    int           last_grant;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a_data[i*W +: W] = a;
        req_b_data[i*W +: W] = b;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_full = 1'b0;
        m_owner = 0;
        for (int i = 0; i < N; i++) sb[i].delete();
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        int           g;
        bit           slot;
        bit           drain;
        logic [N-1:0] er;
        logic [N-1:0] ev;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        slot = !m_full || resp_ready[m_owner];
        er = '0;
        if (g >= 0 && slot) er[g] = 1'b1;
        ev = '0;
        if (m_full) ev[m_owner] = 1'b1;
        check_val("req_ready", 64'(req_ready), 64'(er));
        check_val("resp_valid", 64'(resp_valid), 64'(ev));
        check_val("busy", 64'(busy), 64'(m_full));
        check_val("resp_onehot", 64'($countones(resp_valid) <= 1), 64'd1);
        if (m_full && sb[m_owner].size() > 0)
            check_val("resp_data", 64'(resp_data), 64'(sb[m_owner][0]));
        last_grant = (g >= 0 && slot) ? g : -1;
        drain = m_full && resp_ready[m_owner];
        @(posedge clk);
        if (drain) begin
            void'(sb[m_owner].pop_front());
            m_full = 1'b0;
        end
        if (last_grant >= 0) begin
            sb[g].push_back(req_a_data[g*W +: W] - req_b_data[g*W +: W]);
            m_full  = 1'b1;
            m_owner = g;
            m_ptr   = (g + 1) % N;
        end
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        req_a_data = '0;
        req_b_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_resp_data", 64'(resp_data), 64'd0);
        check_val("rst_req_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin fairness with every requester active
        for (int i = 0; i < N; i++) set_req(i, W'(100 + i), W'(i));
        req_valid  = '1;
        resp_ready = '1;
        for (int k = 0; k < 8; k++) begin
            step();
            check_val("t2_grant", 64'(last_grant), 64'(k % N));
            check_val("t2_data", 64'(resp_data), 64'd100);
            check_val("t2_owner", 64'(resp_valid), 64'(4'b0001 << (k % N)));
        end
        req_valid = '0;
        step();

        // Back-pressure on requester 1 while requester 2 waits
        req_valid  = 4'b0010;
        set_req(1, 32'd7, 32'd3);
        resp_ready = 4'b1101;
        step();
        check_val("t3_grant1", 64'(last_grant), 64'd1);
        req_valid = 4'b0100;
        set_req(2, 32'd50, 32'd8);
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("t3_stall_ready", 64'(req_ready), 64'd0);
            check_val("t3_stall_data", 64'(resp_data), 64'd4);
        end
        resp_ready = 4'b1111;
        step();
        check_val("t3_grant2", 64'(last_grant), 64'd2);
        check_val("t3_data2", 64'(resp_data), 64'd42);
        req_valid = '0;
        step();

        // Modulo-2^32 wrap of the difference
        req_valid = 4'b0001;
        set_req(0, 32'd0, 32'd1);
        step();
        req_valid = '0;
        check_val("t4_wrap_neg", 64'(resp_data), 64'hFFFF_FFFF);
        req_valid = 4'b0001;
        set_req(0, 32'h8000_0000, 32'd1);
        step();
        req_valid = '0;
        check_val("t4_wrap_pos", 64'(resp_data), 64'h7FFF_FFFF);
        step();

        // Pointer skip and wrap
        req_valid = 4'b0100;
        set_req(2, 32'd10, 32'd1);
        step();
        check_val("t5_grant2", 64'(last_grant), 64'd2);
        req_valid = 4'b0010;
        step();
        check_val("t5_grant1", 64'(last_grant), 64'd1);
        req_valid = 4'b1001;
        step();
        check_val("t5_grant3", 64'(last_grant), 64'd3);
        req_valid = 4'b0001;
        step();
        check_val("t5_grant0", 64'(last_grant), 64'd0);
        req_valid = '0;
        step();

        // Asynchronous reset with the buffer full and the owner stalled
        req_valid  = 4'b0010;
        set_req(1, 32'd9, 32'd2);
        resp_ready = '0;
        step();
        req_valid = '0;
        step();
        check_val("t1_full", 64'(busy), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("t1_resp_valid", 64'(resp_valid), 64'd0);
        check_val("t1_busy", 64'(busy), 64'd0);
        check_val("t1_resp_data", 64'(resp_data), 64'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = '1;
        resp_ready = '1;
        for (int i = 0; i < N; i++) set_req(i, W'($urandom), W'($urandom));
        step();
        check_val("t1_first_grant", 64'(last_grant), 64'd0);

        // Random soak; requesters hold their pair until it is taken
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (last_grant == i || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 99) < 60);
                    set_req(i, W'($urandom), W'($urandom));
                end
            end
            resp_ready = N'($urandom);
            step();
        end
        req_valid  = '0;
        resp_ready = '1;
        step();
        step();
        check_val("soak_drained", 64'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
